ahb_master_arb: RTL and testbench
=================================

# ahb_master_arb

Two-port AHB-lite master arbiter that shares the single external M_ AHB master port between the comm controller backend (port 0) and a second on-chip master (port 1). Each port gets a one-entry address-phase holding register and is stalled with HREADY until its transfer has run on the shared bus. Grant is round-robin, optionally overridden by HMSEL. Single, non-pipelined NONSEQ transfers only, matching the backend's AHB usage.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- clk  in  1  clock
- rstn  in  1  reset; **one clock; reset is synchronous and active-low**
- s0_haddr / s1_haddr  in  AW  requester address
- s0_htrans / s1_htrans  in  2  requester transfer type
- s0_hwrite / s1_hwrite  in  1  requester write control
- s0_hsize / s1_hsize  in  3  requester size
- s0_hwdata / s1_hwdata  in  DW  requester write data
- s0_hready / s1_hready  out  1  stall to requester
- s0_hrdata / s1_hrdata  out  DW  read data to requester
- s0_hresp / s1_hresp  out  1  error response to requester
- m_haddr  out  AW  shared bus address
- m_htrans  out  2  shared bus transfer type
- m_hwrite  out  1  shared bus write control
- m_hsize  out  3  shared bus size
- m_hwdata  out  DW  shared bus write data
- m_hrdata  in  DW  shared bus read data
- m_hready  in  1  shared bus ready
- m_hresp  in  1  shared bus error response
- hmsel  in  2  grant override; present only with ARB_HMSEL_EN
- grant  out  2  one-hot owner of the current transfer; 00 when idle

## Operation
- Capture: port N samples a request when sN_htrans[1]=1 and sN_hready=1. NONSEQ and SEQ are both treated as NONSEQ. IDLE and BUSY are ignored.
  - On capture, holdN_vld is set and addr, write and size are registered.
  - sN_hready is 0 from the following cycle until completion.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: if any hold is valid, select a winner, set grant, and go to ADDR.
  - ADDR: drive m_htrans=2'b10 plus the winner's held addr, write and size. Go to DATA when m_hready=1; otherwise stay.
  - DATA: m_htrans=IDLE. m_hwdata is muxed live from the owner's sN_hwdata, which the requester holds stable while stalled. When m_hready=1, clear the owner's hold, advance the round-robin pointer, set grant=00, and return to IDLE.
- Response routing:
  - Owner in DATA: sN_hready=m_hready, sN_hresp=m_hresp, sN_hrdata=m_hrdata, all combinational.
  - Two-cycle ERROR response passes through unchanged: cycle 1 hresp=1 with hready=0, cycle 2 hresp=1 with hready=1.
  - Every other port: hready=!holdN_vld, hresp=0, hrdata=0.
- Round-robin: pointer to the last-served port.
  - When both holds are valid in IDLE, the other port wins.
  - Pointer reset value is 1, so port 0 wins the first tie.
- A new capture on port N cannot occur while holdN_vld=1 (that port is stalled). The other port may capture at any time, including during DATA.
- m_haddr, m_hwrite and m_hsize hold their last value outside ADDR. m_hwdata is 0 outside DATA.
- Reset values: FSM=IDLE, both holds cleared, pointer=1, grant=00, m_htrans=00, m_haddr=m_hwrite=m_hsize=m_hwdata=0, sN_hready=1, sN_hrdata=0, sN_hresp=0.
- rstn low mid-transfer: everything returns to reset values on the next edge and the in-flight transfer is abandoned. The shared slave sees no further NONSEQ.

## Timing
- Request sampled at edge T: hold valid after T, FSM in IDLE during T+1, ADDR during T+2.
- Zero-wait slave: DATA during T+3, with sN_hready=1 in T+3. Minimum of 2 stall cycles seen by the requester.
- Each wait state on m_hready in ADDR or DATA adds one cycle.
- Back-to-back between ports: the loser enters ADDR one cycle after the winner's DATA completes, passing through IDLE. The shared bus is never pipelined.

## Configuration
- ARB_HMSEL_EN defined: hmsel port exists and is sampled in IDLE.
  - 2'b01: only port 0 may be granted.
  - 2'b10: only port 1 may be granted.
  - 2'b00 or 2'b11: round-robin.
  - A blocked port keeps its hold and stays stalled until hmsel permits it.
- Undefined: no hmsel port; always round-robin.

## Test plan
- Port 0 write to 0x4000_0010 with data 0xDEADBEEF, zero-wait slave -> m_htrans=10 with that address two cycles after the request, m_hwdata=0xDEADBEEF in DATA, s0_hready low for exactly 2 cycles.
- Both ports NONSEQ read in the same cycle -> port 0 served first with grant=01, then port 1 with grant=10. s1_hrdata equals the slave value for the second transfer; s0 is unaffected.
- Slave inserts 3 wait states in DATA -> s0_hready low 5 cycles total; hrdata returned on the cycle m_hready=1.
- Slave two-cycle ERROR -> owner sees hresp=1/hready=0, then hresp=1/hready=1. Hold cleared, and the other port's pending request proceeds next.
- ARB_HMSEL_EN with hmsel=10 and port 0 pending -> no grant for port 0 across 20 cycles. After switching to hmsel=00, port 0 is granted within 2 cycles.
- rstn asserted during DATA -> next cycle m_htrans=00, grant=00, both sN_hready=1, and no replay after reset releases.

Source files
------------

// File: rtl/ahb_master_arb.sv
// ahb_master_arb: two-port AHB-lite arbiter sharing one master port, round-robin grant
// Define ARB_HMSEL_EN to add the hmsel grant-override input.
module ahb_master_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW-1:0] s0_haddr,
  input  logic [1:0]    s0_htrans,
  input  logic          s0_hwrite,
  input  logic [2:0]    s0_hsize,
  input  logic [DW-1:0] s0_hwdata,
  output logic          s0_hready,
  output logic [DW-1:0] s0_hrdata,
  output logic          s0_hresp,
  input  logic [AW-1:0] s1_haddr,
  input  logic [1:0]    s1_htrans,
  input  logic          s1_hwrite,
  input  logic [2:0]    s1_hsize,
  input  logic [DW-1:0] s1_hwdata,
  output logic          s1_hready,
  output logic [DW-1:0] s1_hrdata,
  output logic          s1_hresp,
  output logic [AW-1:0] m_haddr,
  output logic [1:0]    m_htrans,
  output logic          m_hwrite,
  output logic [2:0]    m_hsize,
  output logic [DW-1:0] m_hwdata,
  input  logic [DW-1:0] m_hrdata,
  input  logic          m_hready,
  input  logic          m_hresp,
`ifdef ARB_HMSEL_EN
  input  logic [1:0]    hmsel,
`endif
  output logic [1:0]    grant
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t          state;
  logic [1:0]      hold_vld;
  logic [AW-1:0]   hold_addr [2];
  logic [1:0]      hold_write;
  logic [2:0]      hold_size [2];
  logic            ptr;
  logic            owner;
  logic [1:0]      cap;
  logic [1:0]      allowed;
  logic [1:0]      elig;
  logic            win;
  logic            done;
  logic            data0;
  logic            data1;
  always_comb begin
    cap[0] = (s0_htrans == 2'b10) || (s0_htrans == 2'b11);
    cap[0] = cap[0] && s0_hready;
    cap[1] = (s1_htrans == 2'b10) || (s1_htrans == 2'b11);
    cap[1] = cap[1] && s1_hready;
`ifdef ARB_HMSEL_EN
    allowed = (hmsel == 2'b01) ? 2'b01 : (hmsel == 2'b10) ? 2'b10 : 2'b11;
`else
    allowed = 2'b11;
`endif
    elig = hold_vld & allowed;
    // on a tie the port that was not served last wins
    win = (elig == 2'b11) ? ~ptr : elig[1];
    done = (state == DATA) && m_hready;
    data0 = (state == DATA) && !owner;
    data1 = (state == DATA) && owner;
    s0_hready = data0 ? m_hready : !hold_vld[0];
    s0_hresp = data0 ? m_hresp : 1'b0;
    s0_hrdata = data0 ? m_hrdata : '0;
    s1_hready = data1 ? m_hready : !hold_vld[1];
    s1_hresp = data1 ? m_hresp : 1'b0;
    s1_hrdata = data1 ? m_hrdata : '0;
    m_hwdata = (state == DATA) ? (owner ? s1_hwdata : s0_hwdata) : '0;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      hold_vld <= 2'b00;
      hold_addr <= '{default: '0};
      hold_write <= 2'b00;
      hold_size <= '{default: '0};
      ptr <= 1'b1;
      owner <= 1'b0;
      grant <= 2'b00;
      m_htrans <= 2'b00;
      m_haddr <= '0;
      m_hwrite <= 1'b0;
      m_hsize <= 3'b000;
    end else begin
      if (cap[0]) begin
        hold_vld[0] <= 1'b1;
        hold_addr[0] <= s0_haddr;
        hold_write[0] <= s0_hwrite;
        hold_size[0] <= s0_hsize;
      end else if (done && !owner) hold_vld[0] <= 1'b0;
      if (cap[1]) begin
        hold_vld[1] <= 1'b1;
        hold_addr[1] <= s1_haddr;
        hold_write[1] <= s1_hwrite;
        hold_size[1] <= s1_hsize;
      end else if (done && owner) hold_vld[1] <= 1'b0;
      case (state)
        IDLE: if (|elig) begin
          state <= ADDR;
          owner <= win;
          grant <= win ? 2'b10 : 2'b01;
          m_htrans <= 2'b10;
          m_haddr <= win ? hold_addr[1] : hold_addr[0];
          m_hwrite <= win ? hold_write[1] : hold_write[0];
          m_hsize <= win ? hold_size[1] : hold_size[0];
        end
        ADDR: if (m_hready) begin
          state <= DATA;
          m_htrans <= 2'b00;
        end
        default: if (m_hready) begin
          state <= IDLE;
          ptr <= owner;
          grant <= 2'b00;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_master_arb.sv
// tb_ahb_master_arb: directed self-checking bench for ahb_master_arb
module tb_ahb_master_arb;
  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s0_haddr, s1_haddr, s0_hwdata, s1_hwdata, s0_hrdata, s1_hrdata;
  logic [1:0]  s0_htrans, s1_htrans;
  logic        s0_hwrite, s1_hwrite, s0_hready, s1_hready, s0_hresp, s1_hresp;
  logic [2:0]  s0_hsize, s1_hsize;
  logic [31:0] m_haddr, m_hwdata, m_hrdata;
  logic [1:0]  m_htrans, grant;
  logic        m_hwrite, m_hready, m_hresp;
  logic [2:0]  m_hsize;
`ifdef ARB_HMSEL_EN
  logic [1:0]  hmsel = 2'b00;
`endif
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ahb_master_arb #(.AW(32), .DW(32)) dut (
    .clk(clk), .rstn(rstn),
    .s0_haddr(s0_haddr), .s0_htrans(s0_htrans), .s0_hwrite(s0_hwrite), .s0_hsize(s0_hsize),
    .s0_hwdata(s0_hwdata), .s0_hready(s0_hready), .s0_hrdata(s0_hrdata), .s0_hresp(s0_hresp),
    .s1_haddr(s1_haddr), .s1_htrans(s1_htrans), .s1_hwrite(s1_hwrite), .s1_hsize(s1_hsize),
    .s1_hwdata(s1_hwdata), .s1_hready(s1_hready), .s1_hrdata(s1_hrdata), .s1_hresp(s1_hresp),
    .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
    .m_hwdata(m_hwdata), .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp),
`ifdef ARB_HMSEL_EN
    .hmsel(hmsel),
`endif
    .grant(grant)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    s0_htrans = 2'b00;
    s1_htrans = 2'b00;
    m_hready = 1'b1;
    m_hresp = 1'b0;
    step;
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    step;
    @(negedge clk);
    checks++; if (m_htrans !== 2'b00) begin fails++; $display("FAIL rst_htrans got=%h exp=00", m_htrans); end
    checks++; if (grant !== 2'b00) begin fails++; $display("FAIL rst_grant got=%h exp=00", grant); end
    checks++; if ({s0_hready, s1_hready} !== 2'b11) begin fails++; $display("FAIL rst_hready got=%b exp=11", {s0_hready, s1_hready}); end
    checks++; if ({m_haddr, m_hwdata} !== 64'h0) begin fails++; $display("FAIL rst_bus got=%h exp=0", {m_haddr, m_hwdata}); end
    checks++; if ({s0_hrdata, s1_hrdata, s0_hresp, s1_hresp} !== 66'h0) begin fails++; $display("FAIL rst_resp got=%h exp=0", {s0_hrdata, s1_hrdata, s0_hresp, s1_hresp}); end
    step;
    rstn = 1'b1;
  endtask

  task automatic test_single_write;
    int low;
    do_reset;
    s0_haddr = 32'h4000_0010; s0_hwrite = 1'b1; s0_hsize = 3'd2; s0_hwdata = 32'hDEAD_BEEF; s0_htrans = 2'b10;
    step;
    s0_htrans = 2'b00;
    @(negedge clk); low = int'(!s0_hready);
    checks++; if (m_htrans !== 2'b00) begin fails++; $display("FAIL wr_idle_htrans got=%h exp=00", m_htrans); end
    step;
    @(negedge clk); low += int'(!s0_hready);
    checks++; if (m_htrans !== 2'b10) begin fails++; $display("FAIL wr_addr_htrans got=%h exp=10", m_htrans); end
    checks++; if (m_haddr !== 32'h4000_0010) begin fails++; $display("FAIL wr_addr got=%h exp=40000010", m_haddr); end
    checks++; if ({m_hwrite, m_hsize, grant} !== 6'b1_010_01) begin fails++; $display("FAIL wr_ctrl got=%b exp=101001", {m_hwrite, m_hsize, grant}); end
    step;
    @(negedge clk); low += int'(!s0_hready);
    checks++; if (m_hwdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_hwdata got=%h exp=deadbeef", m_hwdata); end
    checks++; if (m_htrans !== 2'b00) begin fails++; $display("FAIL wr_data_htrans got=%h exp=00", m_htrans); end
    step;
    @(negedge clk); low += int'(!s0_hready);
    checks++; if (low !== 2) begin fails++; $display("FAIL wr_stall got=%0d exp=2", low); end
    checks++; if ({grant, m_hwdata} !== 34'h0) begin fails++; $display("FAIL wr_after got=%h exp=0", {grant, m_hwdata}); end
    checks++; if (m_haddr !== 32'h4000_0010) begin fails++; $display("FAIL wr_addr_hold got=%h exp=40000010", m_haddr); end
    step;
  endtask

  task automatic test_tie_read;
    do_reset;
    s0_haddr = 32'h100; s0_hwrite = 1'b0; s0_hsize = 3'd2; s0_htrans = 2'b10;
    s1_haddr = 32'h200; s1_hwrite = 1'b0; s1_hsize = 3'd2; s1_htrans = 2'b10;
    m_hrdata = 32'hAAAA_0001;
    step;
    s0_htrans = 2'b00; s1_htrans = 2'b00;
    step;
    @(negedge clk);
    checks++; if ({grant, m_haddr} !== {2'b01, 32'h100}) begin fails++; $display("FAIL tie_first got=%h exp=%h", {grant, m_haddr}, {2'b01, 32'h100}); end
    step;
    @(negedge clk);
    checks++; if ({s0_hready, s0_hrdata, s1_hready, s1_hrdata} !== {1'b1, 32'hAAAA_0001, 1'b0, 32'h0}) begin fails++; $display("FAIL tie_data0 got=%h", {s0_hready, s0_hrdata, s1_hready, s1_hrdata}); end
    step;
    m_hrdata = 32'hBBBB_0002;
    @(negedge clk);
    checks++; if ({grant, s1_hready} !== 3'b000) begin fails++; $display("FAIL tie_gap got=%b exp=000", {grant, s1_hready}); end
    step;
    @(negedge clk);
    checks++; if ({grant, m_haddr, m_htrans} !== {2'b10, 32'h200, 2'b10}) begin fails++; $display("FAIL tie_second got=%h", {grant, m_haddr, m_htrans}); end
    step;
    @(negedge clk);
    checks++; if ({s1_hready, s1_hrdata} !== {1'b1, 32'hBBBB_0002}) begin fails++; $display("FAIL tie_data1 got=%h exp=1bbbb0002", {s1_hready, s1_hrdata}); end
    checks++; if ({s0_hready, s0_hrdata, s0_hresp} !== {1'b1, 32'h0, 1'b0}) begin fails++; $display("FAIL tie_s0_quiet got=%h", {s0_hready, s0_hrdata, s0_hresp}); end
    step;
  endtask

  task automatic test_wait_states;
    int low;
    logic [31:0] rd;
    do_reset;
    low = 0;
    s0_haddr = 32'h300; s0_hwrite = 1'b0; s0_htrans = 2'b10;
    m_hrdata = 32'h1234_5678;
    step;
    s0_htrans = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      m_hready = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      low += int'(!s0_hready);
      rd = s0_hrdata;
      step;
    end
    checks++; if (low !== 5) begin fails++; $display("FAIL ws_stall got=%0d exp=5", low); end
    checks++; if (rd !== 32'h1234_5678) begin fails++; $display("FAIL ws_rdata got=%h exp=12345678", rd); end
    @(negedge clk);
    checks++; if ({grant, s0_hready} !== 3'b001) begin fails++; $display("FAIL ws_done got=%b exp=001", {grant, s0_hready}); end
    step;
  endtask

  task automatic test_error;
    do_reset;
    s0_haddr = 32'h400; s0_hwrite = 1'b1; s0_hwdata = 32'h5; s0_htrans = 2'b10;
    s1_haddr = 32'h500; s1_hwrite = 1'b0; s1_htrans = 2'b10;
    step;
    s0_htrans = 2'b00; s1_htrans = 2'b00;
    step;
    step;
    m_hready = 1'b0; m_hresp = 1'b1;
    @(negedge clk);
    checks++; if ({s0_hresp, s0_hready} !== 2'b10) begin fails++; $display("FAIL err_cycle1 got=%b exp=10", {s0_hresp, s0_hready}); end
    step;
    m_hready = 1'b1;
    @(negedge clk);
    checks++; if ({s0_hresp, s0_hready, s1_hresp} !== 3'b110) begin fails++; $display("FAIL err_cycle2 got=%b exp=110", {s0_hresp, s0_hready, s1_hresp}); end
    step;
    m_hresp = 1'b0;
    @(negedge clk);
    checks++; if ({s0_hready, s0_hresp, s1_hready} !== 3'b100) begin fails++; $display("FAIL err_cleared got=%b exp=100", {s0_hready, s0_hresp, s1_hready}); end
    step;
    @(negedge clk);
    checks++; if ({grant, m_haddr} !== {2'b10, 32'h500}) begin fails++; $display("FAIL err_next got=%h exp=%h", {grant, m_haddr}, {2'b10, 32'h500}); end
    step;
    @(negedge clk);
    checks++; if ({s1_hready, s1_hresp} !== 2'b10) begin fails++; $display("FAIL err_s1_done got=%b exp=10", {s1_hready, s1_hresp}); end
    step;
  endtask

`ifdef ARB_HMSEL_EN
  task automatic test_hmsel;
    int bad;
    logic got;
    do_reset;
    bad = 0; got = 1'b0;
    hmsel = 2'b10;
    s0_haddr = 32'h600; s0_hwrite = 1'b0; s0_htrans = 2'b10;
    step;
    s0_htrans = 2'b00;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (grant !== 2'b00 || m_htrans !== 2'b00 || s0_hready !== 1'b0) bad++;
      step;
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL hmsel_block got=%0d exp=0", bad); end
    hmsel = 2'b00;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (grant === 2'b01) got = 1'b1;
      step;
    end
    checks++; if (got !== 1'b1) begin fails++; $display("FAIL hmsel_release got=%b exp=1", got); end
    step;
  endtask
`endif

  task automatic test_reset_mid;
    int nonseq;
    do_reset;
    nonseq = 0;
    s0_haddr = 32'h700; s0_hwrite = 1'b1; s0_hwdata = 32'hCAFE; s0_htrans = 2'b10;
    step;
    s0_htrans = 2'b00;
    step;
    step;
    m_hready = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (m_hwdata !== 32'hCAFE) begin fails++; $display("FAIL rm_in_data got=%h exp=cafe", m_hwdata); end
    step;
    rstn = 1'b1; m_hready = 1'b1;
    @(negedge clk);
    checks++; if ({m_htrans, grant, s0_hready, s1_hready} !== 6'b000011) begin fails++; $display("FAIL rm_reset got=%b exp=000011", {m_htrans, grant, s0_hready, s1_hready}); end
    for (int k = 0; k < 8; k++) begin
      step;
      @(negedge clk);
      if (m_htrans === 2'b10 || grant !== 2'b00) nonseq++;
    end
    checks++; if (nonseq !== 0) begin fails++; $display("FAIL rm_replay got=%0d exp=0", nonseq); end
    step;
  endtask

  initial begin
    rstn = 1'b0;
    s0_haddr = '0; s0_htrans = 2'b00; s0_hwrite = 1'b0; s0_hsize = 3'd0; s0_hwdata = '0;
    s1_haddr = '0; s1_htrans = 2'b00; s1_hwrite = 1'b0; s1_hsize = 3'd0; s1_hwdata = '0;
    m_hrdata = '0; m_hready = 1'b1; m_hresp = 1'b0;
    test_reset;
    test_single_write;
    test_tie_read;
    test_wait_states;
    test_error;
`ifdef ARB_HMSEL_EN
    test_hmsel;
`endif
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
